// File: rtl/memory_4k_19bit.sv
// 4K x 19-bit single-port synchronous RAM with a post-reset clear sweep.
// After reset deassertion an internal pointer zeroes every word, one per
// cycle; only then does `ready` rise and normal read/write access begin.
module memory_4k_19bit #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   ptr_d;
  logic [DATA_W-1:0]   dout_q;
  logic                ready_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Single write port shared by the clear sweep and user writes; reset blocks both.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = dataIn;
    ptr_d     = ptr_q + 1'b1;
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
      end else if (wr) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Clear/ready state machine with registered read data and ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          ptr_q <= ptr_d;
          if (ptr_q == PTR_LAST) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end
        end
        S_READY: begin
          // Write-first: a simultaneous read returns the data being written.
          if (rd) begin
            if (wr) begin
              dout_q <= dataIn;
            end else begin
              dout_q <= mem_q[addr];
            end
          end
        end
        default: begin
          state_q <= S_CLEAR;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign dataOut = dout_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_memory_4k_19bit.sv
// Self-checking bench for memory_4k_19bit: directed scenarios plus a
// randomized phase, all compared against a behavioural array model.
module tb_memory_4k_19bit;

  logic        clk;
  logic        rst;
  logic [11:0] addr;
  logic        rd;
  logic        wr;
  logic [18:0] dataIn;
  logic [18:0] dataOut;
  logic        ready;

  int checks;
  int errors;

  // Behavioural model: array contents, expected read data, ready and a
  // count of sweep cycles elapsed since reset was released.
  logic [18:0] m_mem [4096];
  logic [18:0] m_dout;
  logic        m_ready;
  int          m_sweep;

  memory_4k_19bit #(.DATA_W(19), .ADDR_W(12)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .rd     (rd),
    .wr     (wr),
    .dataIn (dataIn),
    .dataOut(dataOut),
    .ready  (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, advance one rising edge, update the model,
  // and leave time 1 unit past the edge for sampling.
  task automatic step(input logic r, input logic w, input logic [11:0] a, input logic [18:0] d);
    rd     = r;
    wr     = w;
    addr   = a;
    dataIn = d;
    @(posedge clk);
    if (rst) begin
      m_ready = 1'b0;
      m_sweep = 0;
      m_dout  = '0;
    end else if (!m_ready) begin
      m_sweep++;
      if (m_sweep == 4096) begin
        foreach (m_mem[i]) m_mem[i] = '0;
        m_ready = 1'b1;
      end
    end else begin
      if (w) begin
        m_mem[a] = d;
        if (r) m_dout = d;
      end else if (r) begin
        m_dout = m_mem[a];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step(1'b0, 1'b0, 12'd0, 19'd0);
    step(1'b1, 1'b1, 12'd5, 19'h1ABCD);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", ready);
    end
    checks++;
    if (dataOut !== 19'd0) begin
      errors++;
      $display("FAIL reset_dout: got %h want 00000", dataOut);
    end
    rst = 1'b0;
    n = 0;
    do begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom), 19'($urandom));
      n++;
    end while (ready !== 1'b1 && n < 5000);
    checks++;
    if (n !== 4096) begin
      errors++;
      $display("FAIL reset_sweep_len: got %0d cycles want 4096", n);
    end
    checks++;
    if (dataOut !== 19'd0) begin
      errors++;
      $display("FAIL reset_dout_after_sweep: got %h want 00000", dataOut);
    end
  endtask

  task automatic test_signed();
    logic [11:0] rdaddr [4];
    logic [18:0] want   [4];
    rdaddr = '{12'd0, 12'd1, 12'd2, 12'd43};
    want   = '{19'd0, 19'd0, 19'd0, 19'h7FFCB};
    step(1'b0, 1'b1, 12'd43, 19'h7FFCB);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, rdaddr[i], 19'($urandom));
      checks++;
      if (dataOut !== want[i]) begin
        errors++;
        $display("FAIL signed_read[%0d]: got %h want %h", rdaddr[i], dataOut, want[i]);
      end
    end
  endtask

  task automatic test_overwrite();
    step(1'b0, 1'b1, 12'd0, 19'd19245);
    step(1'b1, 1'b0, 12'd0, 19'd0);
    checks++;
    if (dataOut !== 19'h04B2D) begin
      errors++;
      $display("FAIL overwrite_addr0: got %h want 04B2D", dataOut);
    end
    step(1'b1, 1'b0, 12'd43, 19'd0);
    checks++;
    if (dataOut !== 19'h7FFCB) begin
      errors++;
      $display("FAIL overwrite_addr43: got %h want 7FFCB", dataOut);
    end
    step(1'b0, 1'b1, 12'd7, 19'h11111);
    step(1'b0, 1'b1, 12'd7, 19'h22222);
    step(1'b1, 1'b0, 12'd7, 19'd0);
    checks++;
    if (dataOut !== 19'h22222) begin
      errors++;
      $display("FAIL overwrite_last_wins: got %h want 22222", dataOut);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b1, 12'd100, 19'h12345);
    checks++;
    if (dataOut !== 19'h12345) begin
      errors++;
      $display("FAIL simul_writethrough: got %h want 12345", dataOut);
    end
    step(1'b1, 1'b0, 12'd1, 19'd0);
    step(1'b1, 1'b0, 12'd100, 19'd0);
    checks++;
    if (dataOut !== 19'h12345) begin
      errors++;
      $display("FAIL simul_readback: got %h want 12345", dataOut);
    end
    // Write without read must not disturb dataOut.
    step(1'b0, 1'b1, 12'd101, 19'h0F0F0);
    checks++;
    if (dataOut !== 19'h12345) begin
      errors++;
      $display("FAIL write_only_hold: got %h want 12345", dataOut);
    end
  endtask

  task automatic test_hold_boundary();
    step(1'b0, 1'b1, 12'd4095, 19'h55555);
    step(1'b1, 1'b0, 12'd4095, 19'd0);
    checks++;
    if (dataOut !== 19'h55555) begin
      errors++;
      $display("FAIL boundary_read4095: got %h want 55555", dataOut);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 12'($urandom), 19'($urandom));
      checks++;
      if (dataOut !== 19'h55555) begin
        errors++;
        $display("FAIL hold_rd0[%0d]: got %h want 55555", i, dataOut);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a, 19'($urandom));
      checks++;
      if (dataOut !== m_dout || ready !== m_ready) begin
        errors++;
        $display("FAIL random[%0d]: got dout=%h ready=%b want dout=%h ready=%b",
                 i, dataOut, ready, m_dout, m_ready);
      end
    end
  endtask

  task automatic test_reset_midsweep();
    int n;
    logic [11:0] probe [4];
    probe = '{12'd0, 12'd43, 12'd100, 12'd4095};
    rst = 1'b1;
    step(1'b0, 1'b0, 12'd0, 19'd0);
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), probe[i % 4], 19'h3FFFF);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_ready_low: got %b want 0", ready);
    end
    rst = 1'b1;
    step(1'b1, 1'b1, 12'd43, 19'h1234);
    rst = 1'b0;
    n = 0;
    do begin
      step(1'b1, 1'b1, probe[n % 4], 19'h6AAAA);
      n++;
    end while (ready !== 1'b1 && n < 5000);
    checks++;
    if (n !== 4096) begin
      errors++;
      $display("FAIL midsweep_len: got %0d cycles want 4096", n);
    end
    checks++;
    if (dataOut !== 19'd0) begin
      errors++;
      $display("FAIL midsweep_dout: got %h want 00000", dataOut);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, probe[i], 19'd0);
      checks++;
      if (dataOut !== 19'd0) begin
        errors++;
        $display("FAIL midsweep_cleared[%0d]: got %h want 00000", probe[i], dataOut);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    m_ready = 1'b0;
    m_sweep = 0;
    m_dout  = '0;
    foreach (m_mem[i]) m_mem[i] = '0;
    rst    = 1'b1;
    rd     = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    dataIn = '0;
    test_reset();
    test_signed();
    test_overwrite();
    test_simultaneous();
    test_hold_boundary();
    test_random();
    test_reset_midsweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
